// File: rtl/fetch_redirect_ctrl.sv
// IF/ID latch with control-flow pre-decode: issues JMP/BRZ redirects back to fetch,
// holds fetch while a BRZ waits on its zero flag, and squashes the wrong-path word.
module fetch_redirect_ctrl #(
    parameter logic [3:0]  OP_JMP       = 4'hC,
    parameter logic [3:0]  OP_BRZ       = 4'hD,
    parameter int unsigned FLAG_TIMEOUT = 8,
    parameter int unsigned CNT_W        = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] if_output,
    input  logic        data_stall,
    input  logic        ex_flag_valid,
    input  logic        ex_zero,
    output logic [8:0]  branch_update_with_isbranch,
    output logic        fetch_hold,
    output logic        id_valid,
    output logic [15:0] id_instr,
    output logic [7:0]  id_pc,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_REDIR = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLAG_TIMEOUT - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
    logic [7:0]       target, target_next;
    logic [8:0]       branch_update_next;
    logic             fetch_hold_next;
    logic             id_valid_next;
    logic [15:0]      id_instr_next;
    logic [7:0]       id_pc_next;
    logic             timeout_err_next;

    logic             advance;
    logic [3:0]       opcode;

    assign advance = ~data_stall;
    assign opcode  = if_output[23:20];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                       <= S_RUN;
            wait_cnt                    <= '0;
            target                      <= '0;
            branch_update_with_isbranch <= '0;
            fetch_hold                  <= 1'b0;
            id_valid                    <= 1'b0;
            id_instr                    <= '0;
            id_pc                       <= '0;
            timeout_err                 <= 1'b0;
        end else begin
            state                       <= state_next;
            wait_cnt                    <= wait_cnt_next;
            target                      <= target_next;
            branch_update_with_isbranch <= branch_update_next;
            fetch_hold                  <= fetch_hold_next;
            id_valid                    <= id_valid_next;
            id_instr                    <= id_instr_next;
            id_pc                       <= id_pc_next;
            timeout_err                 <= timeout_err_next;
        end
    end

    always_comb begin
        state_next         = state;
        wait_cnt_next      = wait_cnt;
        target_next        = target;
        branch_update_next = branch_update_with_isbranch;
        fetch_hold_next    = fetch_hold;
        id_valid_next      = id_valid;
        id_instr_next      = id_instr;
        id_pc_next         = id_pc;
        timeout_err_next   = timeout_err;

        case (state)
            S_RUN: begin
                if (advance) begin
                    id_instr_next = if_output[23:8];
                    id_pc_next    = if_output[7:0];
                    id_valid_next = 1'b1;
                    if (opcode == OP_JMP) begin
                        branch_update_next = {1'b1, if_output[15:8]};
                        state_next         = S_REDIR;
                    end else if (opcode == OP_BRZ) begin
                        target_next     = if_output[15:8];
                        fetch_hold_next = 1'b1;
                        wait_cnt_next   = '0;
                        state_next      = S_WAIT;
                    end
                end
            end
            S_REDIR: begin
                // The word fetched alongside the redirect is wrong-path: keep its PC, drop it.
                if (advance) begin
                    id_valid_next      = 1'b0;
                    id_instr_next      = '0;
                    id_pc_next         = if_output[7:0];
                    branch_update_next = '0;
                    state_next         = S_RUN;
                end
            end
            S_WAIT: begin
                // Resolution ignores data_stall; a flag beats a simultaneous timeout.
                id_valid_next = 1'b0;
                id_instr_next = '0;
                wait_cnt_next = wait_cnt + CNT_W'(1);
                if (ex_flag_valid) begin
                    fetch_hold_next = 1'b0;
                    if (ex_zero) begin
                        branch_update_next = {1'b1, target};
                        state_next         = S_REDIR;
                    end else begin
                        state_next = S_RUN;
                    end
                end else if (wait_cnt == CNT_LAST) begin
                    timeout_err_next = 1'b1;
                    fetch_hold_next  = 1'b0;
                    state_next       = S_RUN;
                end
            end
            default: state_next = S_RUN;
        endcase
    end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed, table-driven check of fetch_redirect_ctrl: JMP, stalled JMP, BRZ taken /
// not taken / flag-at-timeout / timeout, plus an asynchronous reset taken mid-WAIT.
module tb_fetch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] if_output;
    logic        data_stall;
    logic        ex_flag_valid;
    logic        ex_zero;
    logic [8:0]  branch_update_with_isbranch;
    logic        fetch_hold;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [7:0]  id_pc;
    logic        timeout_err;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    fetch_redirect_ctrl #(
        .OP_JMP      (4'hC),
        .OP_BRZ      (4'hD),
        .FLAG_TIMEOUT(8),
        .CNT_W       (4)
    ) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .if_output                  (if_output),
        .data_stall                 (data_stall),
        .ex_flag_valid              (ex_flag_valid),
        .ex_zero                    (ex_zero),
        .branch_update_with_isbranch(branch_update_with_isbranch),
        .fetch_hold                 (fetch_hold),
        .id_valid                   (id_valid),
        .id_instr                   (id_instr),
        .id_pc                      (id_pc),
        .timeout_err                (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] ifo;
        logic        stall;
        logic        fv;
        logic        z;
        logic [8:0]  bu;
        logic        fh;
        logic        iv;
        logic [15:0] ii;
        logic [7:0]  ip;
        logic        te;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic [23:0] ifo, input logic stall, input logic fv,
                               input logic z, input logic [8:0] bu, input logic fh,
                               input logic iv, input logic [15:0] ii, input logic [7:0] ip,
                               input logic te);
        vec_t r;
        r.ifo = ifo; r.stall = stall; r.fv = fv; r.z = z;
        r.bu = bu; r.fh = fh; r.iv = iv; r.ii = ii; r.ip = ip; r.te = te;
        return r;
    endfunction

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [8:0] bu, input logic fh,
                             input logic iv, input logic [15:0] ii, input logic [7:0] ip,
                             input logic te);
        check({tag, ".branch_update"}, 24'(branch_update_with_isbranch), 24'(bu));
        check({tag, ".fetch_hold"},    24'(fetch_hold),  24'(fh));
        check({tag, ".id_valid"},      24'(id_valid),    24'(iv));
        check({tag, ".id_instr"},      24'(id_instr),    24'(ii));
        check({tag, ".id_pc"},         24'(id_pc),       24'(ip));
        check({tag, ".timeout_err"},   24'(timeout_err), 24'(te));
    endtask

    task automatic step(input logic [23:0] ifo, input logic stall, input logic fv, input logic z);
        if_output     = ifo;
        data_stall    = stall;
        ex_flag_valid = fv;
        ex_zero       = z;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hold_cycles;

        rst_n = 1'b0; if_output = '0; data_stall = 1'b0; ex_flag_valid = 1'b0; ex_zero = 1'b0;
        #12;
        check_all("reset", 9'h000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // JMP and immediate squash
        vecs.push_back(v({16'hC042, 8'h05}, 0, 0, 0, 9'h142, 0, 1, 16'hC042, 8'h05, 0));
        vecs.push_back(v({16'h1111, 8'h06}, 0, 0, 0, 9'h000, 0, 0, 16'h0000, 8'h06, 0));
        vecs.push_back(v({16'h1234, 8'h42}, 0, 0, 0, 9'h000, 0, 1, 16'h1234, 8'h42, 0));
        // JMP held across a two-cycle data stall
        vecs.push_back(v({16'hC042, 8'h43}, 0, 0, 0, 9'h142, 0, 1, 16'hC042, 8'h43, 0));
        vecs.push_back(v({16'h2222, 8'h44}, 1, 0, 0, 9'h142, 0, 1, 16'hC042, 8'h43, 0));
        vecs.push_back(v({16'h2222, 8'h44}, 1, 0, 0, 9'h142, 0, 1, 16'hC042, 8'h43, 0));
        vecs.push_back(v({16'h2222, 8'h44}, 0, 0, 0, 9'h000, 0, 0, 16'h0000, 8'h44, 0));
        vecs.push_back(v({16'h3333, 8'h42}, 0, 0, 0, 9'h000, 0, 1, 16'h3333, 8'h42, 0));
        // BRZ taken after three hold cycles
        vecs.push_back(v({16'hD020, 8'h03}, 0, 0, 0, 9'h000, 1, 1, 16'hD020, 8'h03, 0));
        vecs.push_back(v({16'h5555, 8'h04}, 0, 0, 0, 9'h000, 1, 0, 16'h0000, 8'h03, 0));
        vecs.push_back(v({16'h5555, 8'h04}, 0, 0, 0, 9'h000, 1, 0, 16'h0000, 8'h03, 0));
        vecs.push_back(v({16'h5555, 8'h04}, 0, 1, 1, 9'h120, 0, 0, 16'h0000, 8'h03, 0));
        vecs.push_back(v({16'h5555, 8'h04}, 0, 0, 0, 9'h000, 0, 0, 16'h0000, 8'h04, 0));
        // target captured; a stray flag in RUN is ignored
        vecs.push_back(v({16'h6666, 8'h20}, 0, 1, 1, 9'h000, 0, 1, 16'h6666, 8'h20, 0));
        // BRZ not taken
        vecs.push_back(v({16'hD020, 8'h03}, 0, 0, 0, 9'h000, 1, 1, 16'hD020, 8'h03, 0));
        vecs.push_back(v({16'h7777, 8'h04}, 0, 0, 0, 9'h000, 1, 0, 16'h0000, 8'h03, 0));
        vecs.push_back(v({16'h7777, 8'h04}, 0, 0, 0, 9'h000, 1, 0, 16'h0000, 8'h03, 0));
        vecs.push_back(v({16'h7777, 8'h04}, 0, 1, 0, 9'h000, 0, 0, 16'h0000, 8'h03, 0));
        vecs.push_back(v({16'h7777, 8'h04}, 0, 0, 0, 9'h000, 0, 1, 16'h7777, 8'h04, 0));
        // BRZ to 8'hFF: flag arrives on the timeout cycle and wins
        vecs.push_back(v({16'hD0FF, 8'h05}, 0, 0, 0, 9'h000, 1, 1, 16'hD0FF, 8'h05, 0));
        for (int i = 0; i < 7; i++)
            vecs.push_back(v({16'h9999, 8'h06}, 0, 0, 0, 9'h000, 1, 0, 16'h0000, 8'h05, 0));
        vecs.push_back(v({16'h9999, 8'h06}, 0, 1, 1, 9'h1FF, 0, 0, 16'h0000, 8'h05, 0));
        vecs.push_back(v({16'h9999, 8'h06}, 0, 0, 0, 9'h000, 0, 0, 16'h0000, 8'h06, 0));
        vecs.push_back(v({16'hABCD, 8'hFF}, 0, 0, 0, 9'h000, 0, 1, 16'hABCD, 8'hFF, 0));
        // BRZ timeout; counter keeps running through data stalls
        vecs.push_back(v({16'hD020, 8'h03}, 0, 0, 0, 9'h000, 1, 1, 16'hD020, 8'h03, 0));
        for (int i = 0; i < 7; i++)
            vecs.push_back(v({16'h8888, 8'h04}, (i == 2 || i == 3) ? 1'b1 : 1'b0, 0, 0,
                             9'h000, 1, 0, 16'h0000, 8'h03, 0));
        vecs.push_back(v({16'h8888, 8'h04}, 0, 0, 0, 9'h000, 0, 0, 16'h0000, 8'h03, 1));
        vecs.push_back(v({16'h8888, 8'h04}, 0, 0, 0, 9'h000, 0, 1, 16'h8888, 8'h04, 1));
        vecs.push_back(v({16'h4444, 8'h05}, 0, 1, 0, 9'h000, 0, 1, 16'h4444, 8'h05, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].ifo, vecs[i].stall, vecs[i].fv, vecs[i].z);
            check_all($sformatf("vec%0d", i), vecs[i].bu, vecs[i].fh, vecs[i].iv,
                      vecs[i].ii, vecs[i].ip, vecs[i].te);
        end

        // Timeout hold length measured directly: expect exactly 8 cycles
        hold_cycles = 0;
        step({16'hD030, 8'h10}, 0, 0, 0);
        for (int i = 0; i < 20 && fetch_hold; i++) begin
            hold_cycles++;
            step({16'h5A5A, 8'h11}, 0, 0, 0);
        end
        check("timeout_hold_len", 24'(hold_cycles), 24'd8);
        check("timeout_sticky", 24'(timeout_err), 24'd1);
        step({16'h5A5A, 8'h11}, 0, 0, 0);
        check_all("after_timeout", 9'h000, 1'b0, 1'b1, 16'h5A5A, 8'h11, 1'b1);

        // Asynchronous reset in the middle of WAIT
        step({16'hD077, 8'h20}, 0, 0, 0);
        check("pre_reset.fetch_hold", 24'(fetch_hold), 24'd1);
        step({16'h1234, 8'h21}, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_reset", 9'h000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step({16'h1234, 8'h21}, 0, 1, 1);
        check_all("post_reset0", 9'h000, 1'b0, 1'b1, 16'h1234, 8'h21, 1'b0);
        step({16'h2345, 8'h22}, 0, 1, 1);
        check_all("post_reset1", 9'h000, 1'b0, 1'b1, 16'h2345, 8'h22, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
